// File: rtl/tone_generator.sv
// Square-wave tone generator: half-period = frequency ticks of PRESCALE clocks.
// A new divisor is only adopted at a waveform edge, so the output never glitches.
module tone_generator #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DIV_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] frequency,
  output logic             speaker,
  output logic             active,
  output logic             edge_strobe
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             spk_q, spk_d;
  logic             stb_q, stb_d;
  logic             act_q, act_d;

  logic             tick;
  logic [DIV_W-1:0] div_m1;

  assign tick   = (pre_q == PRE_LAST);
  assign div_m1 = div_q - DIV_W'(1);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    spk_d   = spk_q;
    stb_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        spk_d = 1'b0;
        cnt_d = '0;
        pre_d = '0;
        div_d = frequency;
        if (enable && (frequency != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Enable loss wins over any coincident boundary.
          state_d = IDLE;
          spk_d   = 1'b0;
          cnt_d   = '0;
          pre_d   = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + PRE_W'(1);
          if (tick) begin
            if (cnt_q == div_m1) begin
              cnt_d = '0;
              div_d = frequency;
              if (frequency == '0) begin
                state_d = IDLE;
                spk_d   = 1'b0;
              end else begin
                spk_d = ~spk_q;
                stb_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    act_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      spk_q   <= 1'b0;
      stb_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      spk_q   <= spk_d;
      stb_q   <= stb_d;
      act_q   <= act_d;
    end
  end

  assign speaker     = spk_q;
  assign active      = act_q;
  assign edge_strobe = stb_q;

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Downstream consumer of the frequency-select stage. Turns its 15-bit `frequency` word into a square wave on the speaker pin.
- `frequency` is a half-period length, counted in prescaled ticks. Full period = 2 × `frequency` × PRESCALE clock cycles.
- A new divisor is adopted only at a waveform edge, so the output never glitches when the pressed key or game-over state changes.
- Sits between the frequency-select stage and the board buzzer output.

Parameters:
- PRESCALE, 1: clock cycles per count tick. Legal range ≥ 1.
- DIV_W, 15: width of the `frequency` input and the half-period counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  sound enable. Low forces silence.
- frequency  input  DIV_W  half-period length in ticks. 0 means mute.
- speaker  output  1  square-wave output.
- active  output  1  high while state = RUN.
- edge_strobe  output  1  one-cycle pulse on the cycle `speaker` toggles.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - speaker = 0, active = 0, edge_strobe = 0.
  - Prescale counter `pre` = 0, half-period counter `cnt` = 0, latched divisor `cur_div` = 0.
  - rst has priority over every other input.
- Tick generation:
  - `pre` counts 0..PRESCALE-1 in RUN only and wraps to 0.
  - `tick` = (pre == PRESCALE-1).
  - With PRESCALE=1, `tick` is high every RUN cycle.
- State IDLE:
  - speaker = 0, cnt = 0, pre = 0, cur_div <= frequency every cycle.
  - Go to RUN when enable=1 and frequency≠0. On that edge: cur_div <= frequency, cnt <= 0, pre <= 0, speaker stays 0.
- State RUN, with enable=1, on each tick:
  - If cnt == cur_div-1:
    - speaker toggles, edge_strobe = 1 for one cycle.
    - cnt <= 0, and cur_div <= frequency (shadow load at the boundary only).
    - If frequency == 0 at this boundary: go to IDLE, speaker <= 0, edge_strobe <= 0.
  - Otherwise cnt <= cnt+1.
- State RUN, non-tick cycles: counters hold except `pre`. edge_strobe = 0.
- Changes on `frequency` mid-half-period are ignored until the next boundary. The current half-period always completes at the old length.
- enable=0 in RUN: IDLE on the next edge, speaker <= 0, counters cleared. There is no wait for a boundary.
- Latency (PRESCALE=1): enable rises while frequency=N.
  - RUN is entered at the next edge.
  - The first speaker rise comes N clocks later.
  - Subsequent toggles come every N clocks.
- Width rules:
  - cnt and cur_div are DIV_W bits.
  - The compare uses cur_div-1 computed at DIV_W bits; cur_div≥1 is guaranteed in RUN.
  - frequency = 2^DIV_W-1 is legal and gives the maximum half-period.
- Simultaneous events:
  - enable=0 coinciding with a boundary: IDLE wins and speaker = 0. The toggle is not taken and edge_strobe stays 0.
  - rst at any point, including mid-half-period, returns to the reset values on the next edge.
- active = 1 exactly while state = RUN.

Test Plan:
- Steady tone: PRESCALE=1, frequency=4, enable=1 after reset → speaker rises 4 clocks after RUN entry. Period is 8 clocks. edge_strobe pulses every 4 clocks. active = 1.
- Prescaled tone: PRESCALE=3, frequency=2 → speaker toggles every 6 clocks. Full period is 12 clocks.
- Mid-period change: PRESCALE=1, frequency=5 → 2 applied 2 clocks into a half-period → that half-period still lasts 5 clocks. Subsequent half-periods are 2 clocks. No runt pulse.
- Mute via divisor: RUN at frequency=3, frequency set to 0 → at the next boundary speaker = 0, active = 0, state IDLE. No toggle strobe on that boundary.
- Enable drop and boundary collision: enable=0 on the same cycle cnt reaches cur_div-1 → next cycle speaker = 0, active = 0, edge_strobe = 0. Re-enable with frequency=4 → first rise 4 clocks after RUN entry.
- Reset mid-operation: rst=1 while speaker = 1 in RUN → next edge speaker = 0, active = 0, edge_strobe = 0, counters 0. Releasing rst with enable=1 restarts cleanly.
